conv_pe_channel_accumulator: RTL and testbench
==============================================

# conv_pe_channel_accumulator

Parametrised successor to the single-pass 3x3 convolution PE. It accepts a stream of 3x3 windows for each input channel and computes the 9-tap multiply-add in a fixed 2-stage pipeline. Results accumulate across all input channels of one output channel in an internal buffer; the bias is folded in on the first channel. When the last channel completes, the block streams the requantised map out (shift, optional ReLU, saturate). It sits between the line-buffer/window generator and the output writer of the Conv2d engine.

## Interface
Parameters:
- PIXEL_WIDTH, 16: signed window tap width.
- KERNEL_WIDTH, 16: signed kernel tap width.
- RESULT_WIDTH, 48: signed accumulator width.
- OUT_WIDTH, 16: signed output width.
- MAP_PIXELS, 16384: pixels per feature map. Minimum 4.
- ADDR_WIDTH, $clog2(MAP_PIXELS): buffer address width.
- FRAC_SHIFT, 8: arithmetic right shift applied at readout.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  job start request; accepted when cfg_ready=1.
- cfg_ready  out  1  high only in IDLE.
- cfg_num_ch  in  16  input channels in the job; 0 is treated as 1.
- cfg_relu  in  1  clamp negatives to 0 at readout.
- cfg_bias  in  RESULT_WIDTH  signed bias, latched at accept.
- kernel_flat  in  9*KERNEL_WIDTH  tap j at bits [(9-j)*KERNEL_WIDTH-1 -: KERNEL_WIDTH], j=0..8 row-major.
- kernel_valid / kernel_ready  in / out  1  kernel handshake, once per channel.
- win_flat  in  9*PIXEL_WIDTH  window, same packing as the kernel.
- win_valid / win_ready  in / out  1  window handshake.
- out_data  out  OUT_WIDTH  requantised result.
- out_valid / out_ready  out / in  1  output handshake.
- out_last  out  1  qualifies the beat for pixel MAP_PIXELS-1.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the final output beat.

## Operation
- State machine: IDLE → LOAD_K → STREAM → DRAIN, then either LOAD_K again (channels remain) or READOUT → IDLE.
- IDLE:
  - On cfg_valid, latch num_ch, relu and bias.
  - Clear the channel counter ch and the pixel counter pix.
  - cfg_valid outside IDLE is ignored.
- LOAD_K:
  - kernel_ready=1.
  - On handshake, register the 9 taps and go to STREAM.
- STREAM:
  - win_ready=1; each accepted window gets address pix, and pix increments.
  - The window that hits pix=MAP_PIXELS-1 moves the FSM to DRAIN, with pix wrapping to 0.
  - The pipeline never stalls, so every accepted window produces exactly one buffer write.
- Per-window arithmetic:
  - sum = Σ sign-extended tap products, at full RESULT_WIDTH.
  - On ch==0: buf[a] ← sum + bias. The buffer is not read, so its stale contents are irrelevant.
  - On ch>0: buf[a] ← sum + buf[a], with wrap-around two's-complement addition.
- DRAIN:
  - Wait 3 cycles for the pipeline to empty, then ch++.
  - If ch==num_ch, go to READOUT; otherwise go to LOAD_K.
- READOUT:
  - Read buf[0..MAP_PIXELS-1] in order.
  - Per value: v = buf >>> FRAC_SHIFT; if relu and v<0, v=0; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Output goes through a 2-entry skid buffer, giving full throughput.
  - After the out_last handshake, pulse done and return to IDLE.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Counters, kernel registers and the pipeline are cleared.
  - Buffer contents are left undefined; correctness does not depend on them because ch==0 ignores the buffer.
  - A reset mid-job aborts the job with no done pulse.

## Timing
- A window accepted in cycle t:
  - Products are registered at t+1.
  - The adder-tree sum is registered at t+2.
  - The buffer read is issued at t+1 and its data is valid at t+2.
  - The write of buf[a] occurs at the t+2 clock edge and is readable from t+3.
- No read-after-write hazard: addresses within a pass are distinct, and DRAIN guarantees every write of pass n lands before the first read of pass n+1.
- win_ready falls in the cycle after the last accept.
- kernel_ready rises 4 cycles after the last window accept of the previous pass.
- READOUT:
  - First out_valid appears 2 cycles after entering the state.
  - Sustains 1 beat per cycle while out_ready=1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- done is asserted the cycle after the final handshake. busy falls in that same cycle.

## Structure
- Shared package conv_pkg:
  - State enum (IDLE, LOAD_K, STREAM, DRAIN, READOUT).
  - Tap count constant 9.
  - Drain depth constant 3.
  - Saturation helper function.
- Sub-module pe_mac9: 2-stage 9-tap multiply and adder tree.
- The accumulation buffer is a simple dual-port RAM (one write port, one read port, 1-cycle read latency), inferred inline.
- The FSM, counters and skid buffer are in the top module.

## Test plan
Unless stated otherwise, benches use MAP_PIXELS=16 and FRAC_SHIFT=0.
- num_ch=1, all kernel taps 1, all window taps 1, bias 0 → 16 beats of 9; out_last on beat 16; done once.
- num_ch=3, kernel centre 2 with others 0, window centre = pixel index i, bias 5 → out[i] = 5 + 6i.
- Saturation/ReLU, num_ch=1, kernel centre 1:
  - Window centre -100 with relu=1 → 0.
  - Window centre 32767 with bias 10 → 32767.
  - FRAC_SHIFT=8, bias 0, window centre -512 with relu=0 → -2.
- out_ready toggled randomly in test 2 → identical sequence, no drops or duplicates, data held while stalled.
- rst asserted mid-STREAM of channel 1 → outputs 0, state IDLE, no done; a following test-2 job gives correct results.
- cfg_num_ch=0 → behaves as a single pass.
- cfg_valid pulsed during READOUT → ignored; only one done is produced.

Source files
------------

// File: rtl/conv_pe_channel_accumulator_pkg.sv
// conv_pkg: shared types and helpers for the channel-accumulating 3x3 conv PE.
//   state_e    - top-level job sequencer states
//   NUM_TAPS   - taps per 3x3 window / kernel
//   DRAIN_DEPTH- cycles spent in DRAIN so the MAC pipeline and buffer write settle
//   sat_check  - classifies a signed value against an N-bit signed range
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    STREAM,
    DRAIN,
    READOUT
  } state_e;

  localparam int unsigned NUM_TAPS    = 9;
  localparam int unsigned DRAIN_DEPTH = 3;

  // Width the saturation helper works at; callers sign-extend into it.
  localparam int unsigned SAT_W = 128;

  typedef enum logic [1:0] {
    SAT_PASS,
    SAT_HI,
    SAT_LO
  } sat_e;

  function automatic sat_e sat_check(input logic signed [SAT_W-1:0] v,
                                     input int unsigned            w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_PASS;
  endfunction

endpackage

// File: rtl/conv_pe_channel_accumulator_pe_mac9.sv
// pe_mac9: 2-stage signed 9-tap multiply / adder tree.
//   stage 1 registers the nine products of win_flat and kernel_flat,
//   stage 2 registers their sign-extended sum. No stall input: a window
//   presented in cycle t has its sum on 'sum' in cycle t+2.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (clears both stages)
//   win_flat     - 9 window taps, tap j at [(9-j)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]
//   kernel_flat  - 9 kernel taps, same packing
//   sum          - registered 9-tap dot product, RESULT_WIDTH signed
module pe_mac9
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int RESULT_WIDTH = 48
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_TAPS*PIXEL_WIDTH-1:0]     win_flat,
  input  logic [NUM_TAPS*KERNEL_WIDTH-1:0]    kernel_flat,
  output logic signed [RESULT_WIDTH-1:0]      sum
);

  localparam int PROD_W = PIXEL_WIDTH + KERNEL_WIDTH;

  logic signed [PROD_W-1:0]       prod_d [NUM_TAPS];
  logic signed [PROD_W-1:0]       prod_q [NUM_TAPS];
  logic signed [RESULT_WIDTH-1:0] sum_d;

  always_comb begin
    for (int j = 0; j < NUM_TAPS; j++) begin
      prod_d[j] = PROD_W'($signed(win_flat[(NUM_TAPS-j)*PIXEL_WIDTH-1 -: PIXEL_WIDTH]))
                * PROD_W'($signed(kernel_flat[(NUM_TAPS-j)*KERNEL_WIDTH-1 -: KERNEL_WIDTH]));
    end
  end

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < NUM_TAPS; j++) begin
      sum_d = sum_d + RESULT_WIDTH'(prod_q[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_TAPS; j++) prod_q[j] <= '0;
      sum <= '0;
    end else begin
      for (int j = 0; j < NUM_TAPS; j++) prod_q[j] <= prod_d[j];
      sum <= sum_d;
    end
  end

endmodule

// File: rtl/conv_pe_channel_accumulator.sv
// conv_pe_channel_accumulator: accumulates 3x3 convolutions over all input
// channels of one output channel into an internal map buffer, then streams
// the requantised map (shift, optional ReLU, saturate).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   cfg_valid/cfg_ready         - job start; cfg_num_ch (0 means 1), cfg_relu, cfg_bias
//   kernel_flat, kernel_valid/kernel_ready - one kernel per channel
//   win_flat, win_valid/win_ready          - MAP_PIXELS windows per channel
//   out_data, out_valid/out_ready, out_last - requantised map stream
//   busy                        - job in progress
//   done                        - one-cycle pulse after the last output beat
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cfg_valid; latches job config
// LOAD_K  | waiting for this channel's kernel
// STREAM  | accepting windows, one buffer write per window
// DRAIN   | DRAIN_DEPTH cycles for the MAC pipeline and last write to land
// READOUT | reading buffer in order through requant + 2-entry skid
module conv_pe_channel_accumulator
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 16,
  parameter int KERNEL_WIDTH = 16,
  parameter int RESULT_WIDTH = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int MAP_PIXELS   = 16384,
  parameter int ADDR_WIDTH   = $clog2(MAP_PIXELS),
  parameter int FRAC_SHIFT   = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [15:0]                       cfg_num_ch,
  input  logic                              cfg_relu,
  input  logic [RESULT_WIDTH-1:0]           cfg_bias,
  input  logic [NUM_TAPS*KERNEL_WIDTH-1:0]  kernel_flat,
  input  logic                              kernel_valid,
  output logic                              kernel_ready,
  input  logic [NUM_TAPS*PIXEL_WIDTH-1:0]   win_flat,
  input  logic                              win_valid,
  output logic                              win_ready,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX   = ADDR_WIDTH'(MAP_PIXELS - 1);
  localparam logic [1:0]            DRAIN_LOAD = 2'(DRAIN_DEPTH - 1);

  state_e                           state_q, state_d;
  logic [15:0]                      num_ch_q, ch_q;
  logic                             relu_q;
  logic signed [RESULT_WIDTH-1:0]   bias_q;
  logic [NUM_TAPS*KERNEL_WIDTH-1:0] kernel_q;
  logic [ADDR_WIDTH-1:0]            pix_q;
  logic [1:0]                       drain_cnt_q;

  logic win_hs, pix_last, last_ch;

  logic                           s1_valid, s1_first, s2_valid, s2_first;
  logic [ADDR_WIDTH-1:0]          s1_addr, s2_addr, rd_addr;
  logic signed [RESULT_WIDTH-1:0] mac_sum, rd_data_q, wr_data;
  logic signed [RESULT_WIDTH-1:0] acc_mem [MAP_PIXELS];

  logic                   issue, push, pop, issued_all_q, inflight_q, inflight_last_q;
  logic [2:0]             pending;
  logic [OUT_WIDTH-1:0]   fifo_data_q [2];
  logic [1:0]             fifo_last_q;
  logic                   fifo_wr_q, fifo_rd_q;
  logic [1:0]             fifo_cnt_q;
  logic signed [RESULT_WIDTH-1:0] shifted, relu_v;
  logic [OUT_WIDTH-1:0]   rq_data;

  assign win_hs   = (state_q == STREAM) & win_valid;
  assign pix_last = (pix_q == LAST_PIX);
  assign last_ch  = ((ch_q + 16'd1) == num_ch_q);

  always_comb begin
    state_d      = state_q;
    cfg_ready    = 1'b0;
    kernel_ready = 1'b0;
    win_ready    = 1'b0;
    busy         = 1'b1;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) state_d = LOAD_K;
      end
      LOAD_K: begin
        kernel_ready = 1'b1;
        if (kernel_valid) state_d = STREAM;
      end
      STREAM: begin
        win_ready = 1'b1;
        if (win_valid && pix_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt_q == 2'd0) state_d = last_ch ? READOUT : LOAD_K;
      end
      READOUT: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pe_mac9 #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .KERNEL_WIDTH (KERNEL_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .win_flat    (win_flat),
    .kernel_flat (kernel_q),
    .sum         (mac_sum)
  );

  // The read port follows the MAC pipeline during passes (so the old partial
  // sum lines up with stage 2) and the readout pointer during READOUT.
  assign rd_addr = (state_q == READOUT) ? pix_q : s1_addr;
  assign wr_data = mac_sum + (s2_first ? bias_q : rd_data_q);

  always_ff @(posedge clk) begin
    if (s2_valid) acc_mem[s2_addr] <= wr_data;
    rd_data_q <= acc_mem[rd_addr];
  end

  always_comb begin
    shifted = rd_data_q >>> FRAC_SHIFT;
    relu_v  = (relu_q && shifted[RESULT_WIDTH-1]) ? '0 : shifted;
    unique case (sat_check(SAT_W'(relu_v), OUT_WIDTH))
      SAT_HI:  rq_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      SAT_LO:  rq_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      default: rq_data = relu_v[OUT_WIDTH-1:0];
    endcase
  end

  // Reads are only issued while the skid has room for everything already
  // in flight, so a stalled consumer never loses a beat.
  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = fifo_data_q[fifo_rd_q];
  assign out_last  = out_valid & fifo_last_q[fifo_rd_q];
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;
  assign pending   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == READOUT) & ~issued_all_q & (pending < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      num_ch_q        <= 16'd1;
      ch_q            <= '0;
      relu_q          <= 1'b0;
      bias_q          <= '0;
      kernel_q        <= '0;
      pix_q           <= '0;
      drain_cnt_q     <= '0;
      s1_valid        <= 1'b0;
      s1_first        <= 1'b0;
      s1_addr         <= '0;
      s2_valid        <= 1'b0;
      s2_first        <= 1'b0;
      s2_addr         <= '0;
      issued_all_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q     <= '0;
      fifo_wr_q       <= 1'b0;
      fifo_rd_q       <= 1'b0;
      fifo_cnt_q      <= '0;
      done            <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == READOUT) & pop & out_last;

      if (state_q == IDLE && cfg_valid) begin
        num_ch_q     <= (cfg_num_ch == 16'd0) ? 16'd1 : cfg_num_ch;
        relu_q       <= cfg_relu;
        bias_q       <= cfg_bias;
        ch_q         <= '0;
        pix_q        <= '0;
        issued_all_q <= 1'b0;
      end

      if (state_q == LOAD_K && kernel_valid) kernel_q <= kernel_flat;

      s1_valid <= win_hs;
      s1_addr  <= pix_q;
      s1_first <= (ch_q == 16'd0);
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_first <= s1_first;

      if (win_hs) begin
        pix_q <= pix_last ? '0 : pix_q + ADDR_WIDTH'(1);
        if (pix_last) drain_cnt_q <= DRAIN_LOAD;
      end

      if (state_q == DRAIN) begin
        if (drain_cnt_q == 2'd0) ch_q <= ch_q + 16'd1;
        else                     drain_cnt_q <= drain_cnt_q - 2'd1;
      end

      if (issue) begin
        pix_q <= pix_last ? '0 : pix_q + ADDR_WIDTH'(1);
        if (pix_last) issued_all_q <= 1'b1;
      end
      inflight_q      <= issue;
      inflight_last_q <= issue & pix_last;

      if (push) begin
        fifo_data_q[fifo_wr_q] <= rq_data;
        fifo_last_q[fifo_wr_q] <= inflight_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_conv_pe_channel_accumulator.sv
module tb_conv_pe_channel_accumulator;

  localparam int MAP = 16;
  localparam int PW  = 16;
  localparam int KW  = 16;
  localparam int RW  = 48;
  localparam int OW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           cfg_valid, cfg_relu, kernel_valid, win_valid, out_ready;
  logic [15:0]    cfg_num_ch;
  logic [RW-1:0]  cfg_bias;
  logic [9*KW-1:0] kernel_flat;
  logic [9*PW-1:0] win_flat;
  logic           cfg_ready, kernel_ready, win_ready, out_valid, out_last, busy, done;
  logic [OW-1:0]  out_data;
  logic           f8_cfg_ready, f8_kernel_ready, f8_win_ready, f8_out_valid, f8_out_last, f8_busy, f8_done;
  logic [OW-1:0]  f8_out_data;

  conv_pe_channel_accumulator #(
    .PIXEL_WIDTH(PW), .KERNEL_WIDTH(KW), .RESULT_WIDTH(RW), .OUT_WIDTH(OW),
    .MAP_PIXELS(MAP), .FRAC_SHIFT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_num_ch(cfg_num_ch),
    .cfg_relu(cfg_relu), .cfg_bias(cfg_bias),
    .kernel_flat(kernel_flat), .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
    .win_flat(win_flat), .win_valid(win_valid), .win_ready(win_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  conv_pe_channel_accumulator #(
    .PIXEL_WIDTH(PW), .KERNEL_WIDTH(KW), .RESULT_WIDTH(RW), .OUT_WIDTH(OW),
    .MAP_PIXELS(MAP), .FRAC_SHIFT(8)
  ) dut_f8 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(f8_cfg_ready), .cfg_num_ch(cfg_num_ch),
    .cfg_relu(cfg_relu), .cfg_bias(cfg_bias),
    .kernel_flat(kernel_flat), .kernel_valid(kernel_valid), .kernel_ready(f8_kernel_ready),
    .win_flat(win_flat), .win_valid(win_valid), .win_ready(f8_win_ready),
    .out_data(f8_out_data), .out_valid(f8_out_valid), .out_ready(out_ready), .out_last(f8_out_last),
    .busy(f8_busy), .done(f8_done)
  );

  int cyc = 0;
  int done_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    longint acc;
    bit     last;
    bit     relu;
  } exp_t;
  exp_t sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  function automatic logic [143:0] pack9(input logic signed [15:0] t [9]);
    logic [143:0] r;
    for (int j = 0; j < 9; j++) r[(9-j)*16-1 -: 16] = t[j];
    return r;
  endfunction

  function automatic longint dot9(input logic signed [15:0] a [9],
                                  input logic signed [15:0] b [9]);
    longint d = 0;
    for (int j = 0; j < 9; j++) d += longint'(a[j]) * longint'(b[j]);
    return d;
  endfunction

  function automatic longint rq(input longint a, input int sh, input bit relu);
    longint v = a >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  // mode 0: all-ones taps; 1: kernel centre 2, window centre = pixel index;
  // 2: kernel centre 1, window centre = cval; 3: random taps, random gaps.
  task automatic run_job(input string tag, input int nch_cfg, input bit relu,
                         input longint bias, input int mode, input int cval,
                         input bit rand_rdy, input int abort_ch, input bit cfg_poke);
    longint acc [MAP];
    logic signed [15:0] k [9];
    logic signed [15:0] w [9];
    int nch, n, got, c_last, first_cyc, done_before;
    bit stall_prev, held_last;
    logic [15:0] held;
    exp_t e;

    nch = (nch_cfg == 0) ? 1 : nch_cfg;
    done_before = done_cnt;
    c_last = cyc;
    cfg_num_ch = 16'(nch_cfg);
    cfg_relu   = relu;
    cfg_bias   = RW'(bias);
    cfg_valid  = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail({tag, ".cfg"});
    tick();
    cfg_valid = 1'b0;

    for (int c = 0; c < nch; c++) begin
      for (int j = 0; j < 9; j++) begin
        case (mode)
          0:       k[j] = 16'sd1;
          1:       k[j] = (j == 4) ? 16'sd2 : 16'sd0;
          2:       k[j] = (j == 4) ? 16'sd1 : 16'sd0;
          default: k[j] = 16'(int'($urandom_range(0, 100)) - 50);
        endcase
      end
      kernel_flat  = pack9(k);
      kernel_valid = 1'b1;
      n = 0;
      while (!kernel_ready && n < 50) begin tick(); n++; end
      if (n >= 50) timeout_fail({tag, ".kernel"});
      tick();
      kernel_valid = 1'b0;
      if (c > 0) check({tag, ".kready_lat"}, cyc - c_last, 4);

      for (int p = 0; p < MAP; p++) begin
        for (int j = 0; j < 9; j++) begin
          case (mode)
            0:       w[j] = 16'sd1;
            1:       w[j] = (j == 4) ? 16'(p) : 16'(int'($urandom_range(0, 2000)) - 1000);
            2:       w[j] = (j == 4) ? 16'(cval) : 16'(int'($urandom_range(0, 2000)) - 1000);
            default: w[j] = 16'(int'($urandom_range(0, 100)) - 50);
          endcase
        end
        if (c == 0) acc[p] = bias + dot9(k, w);
        else        acc[p] = acc[p] + dot9(k, w);
        if (mode == 3 && $urandom_range(0, 3) == 0) begin
          win_valid = 1'b0;
          tick();
        end
        win_flat  = pack9(w);
        win_valid = 1'b1;
        n = 0;
        while (!win_ready && n < 50) begin tick(); n++; end
        if (n >= 50) timeout_fail({tag, ".win"});
        tick();
        if (c == abort_ch && p == 5) begin
          win_valid = 1'b0;
          rst = 1'b1;
          tick();
          check({tag, ".rst_out_valid"}, out_valid, 0);
          check({tag, ".rst_busy"}, busy, 0);
          check({tag, ".rst_cfg_ready"}, cfg_ready, 1);
          check({tag, ".rst_win_ready"}, win_ready, 0);
          check({tag, ".rst_out_data"}, out_data, 0);
          rst = 1'b0;
          tick();
          tick();
          check({tag, ".rst_no_done"}, done_cnt - done_before, 0);
          return;
        end
      end
      win_valid = 1'b0;
      c_last = cyc;
      check({tag, ".win_ready_fall"}, win_ready, 0);
    end

    for (int p = 0; p < MAP; p++) begin
      e.acc  = acc[p];
      e.last = (p == MAP - 1);
      e.relu = relu;
      sb.push_back(e);
    end

    got = 0;
    n = 0;
    stall_prev = 1'b0;
    first_cyc = -1;
    held = '0;
    held_last = 1'b0;
    while (got < MAP && n < 500) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_valid = cfg_poke && (n == 6);
      #1;
      if (out_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check({tag, ".first_valid_lat"}, first_cyc - c_last, 5);
        end
        if (stall_prev) begin
          check({tag, ".hold_data"}, out_data, held);
          check({tag, ".hold_last"}, out_last, held_last);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            timeout_fail({tag, ".sb_empty"});
          end else begin
            e = sb.pop_front();
            check({tag, ".data"}, $signed(out_data), rq(e.acc, 0, e.relu));
            check({tag, ".data_f8"}, $signed(f8_out_data), rq(e.acc, 8, e.relu));
            check({tag, ".last"}, out_last, e.last);
          end
          got++;
          stall_prev = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held = out_data;
          held_last = out_last;
        end
      end
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    out_ready = 1'b0;
    if (got < MAP) timeout_fail({tag, ".readout"});
    check({tag, ".done_pulse"}, done, 1);
    check({tag, ".busy_fall"}, busy, 0);
    tick();
    check({tag, ".done_clear"}, done, 0);
    repeat (3) tick();
    check({tag, ".done_count"}, done_cnt - done_before, 1);
    check({tag, ".idle_after"}, busy, 0);
    check({tag, ".sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_valid = 1'b0; cfg_relu = 1'b0; cfg_num_ch = '0; cfg_bias = '0;
    kernel_flat = '0; kernel_valid = 1'b0; win_flat = '0; win_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset.out_valid", out_valid, 0);
    check("reset.out_last", out_last, 0);
    check("reset.out_data", out_data, 0);
    check("reset.done", done, 0);
    check("reset.busy", busy, 0);
    check("reset.cfg_ready", cfg_ready, 1);
    check("reset.kernel_ready", kernel_ready, 0);
    check("reset.win_ready", win_ready, 0);
    rst = 1'b0;
    tick();

    run_job("t1_ones",     1, 1'b0, 0,     0, 0,      1'b0, -1, 1'b0);
    run_job("t2_3ch",      3, 1'b0, 5,     1, 0,      1'b0, -1, 1'b0);
    run_job("t3a_relu",    1, 1'b1, 0,     2, -100,   1'b0, -1, 1'b0);
    run_job("t3b_sat",     1, 1'b0, 10,    2, 32767,  1'b0, -1, 1'b0);
    run_job("t3c_neg",     1, 1'b0, 0,     2, -512,   1'b0, -1, 1'b0);
    run_job("t4_stall",    3, 1'b0, 5,     1, 0,      1'b1, -1, 1'b0);
    run_job("t5_abort",    3, 1'b0, 5,     1, 0,      1'b0, 1,  1'b0);
    run_job("t5_after",    3, 1'b0, 5,     1, 0,      1'b1, -1, 1'b0);
    run_job("t6_nch0",     0, 1'b0, 7,     3, 0,      1'b0, -1, 1'b0);
    run_job("t7_poke",     2, 1'b0, -300,  3, 0,      1'b1, -1, 1'b1);
    run_job("t8_rand_relu",2, 1'b1, 1000,  3, 0,      1'b1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
